bp_fe_fill_arbiter: RTL and testbench

- Shares the single I$ cache-engine request port between two requesters: the demand-miss path (bp_fe_icache) and the next-line prefetcher.
- Holds one request in a registered skid stage and tracks outstanding engine credits.
- Reserves one credit for demand traffic and bounds prefetch starvation.
- Routes each cache_req_complete pulse back to the requester that owns it, in issue order.

---
 rtl/bp_fe_fill_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bp_fe_fill_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_fill_arbiter.sv
// bp_fe_fill_arbiter
// Shares the single I$ cache-engine request port between the demand-miss path
// and the next-line prefetcher. One request is held in a registered skid stage.
// Outstanding engine requests are tracked as credits, with one credit kept back
// for demand traffic. A small owner FIFO routes each completion back to the
// requester that issued it, in issue order.
module bp_fe_fill_arbiter #(
  parameter int req_width_p    = 32,
  parameter int credits_p      = 4,
  parameter int starve_limit_p = 3,
  parameter bit check_proto_p  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,

  input  logic [req_width_p-1:0] dmd_req_i,
  input  logic                   dmd_v_i,
  output logic                   dmd_ready_and_o,
  output logic                   dmd_complete_o,

  input  logic [req_width_p-1:0] pf_req_i,
  input  logic                   pf_v_i,
  output logic                   pf_ready_and_o,
  output logic                   pf_complete_o,

  output logic [req_width_p-1:0] cache_req_o,
  output logic                   cache_req_v_o,
  input  logic                   cache_req_ready_and_i,
  input  logic                   cache_req_complete_i,

  output logic                   credits_full_o,
  output logic                   credits_empty_o
);

  localparam int cnt_w_lp = $clog2(credits_p + 1);
  localparam int ptr_w_lp = (credits_p > 1) ? $clog2(credits_p) : 1;
  localparam int stv_w_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;

  localparam logic [cnt_w_lp-1:0] credits_lp    = cnt_w_lp'(credits_p);
  localparam logic [cnt_w_lp-1:0] pf_cap_lp     = cnt_w_lp'(credits_p - 1);
  localparam logic [stv_w_lp-1:0] starve_lim_lp = stv_w_lp'(starve_limit_p);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp   = ptr_w_lp'(credits_p - 1);

  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_send = 1'b1;

  // Control state
  logic [0:0]             state_q,  state_d;
  logic [cnt_w_lp-1:0]    count_q,  count_d;
  logic [stv_w_lp-1:0]    starve_q, starve_d;
  logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;

  // Data state: held packet, its owner, and the owner FIFO storage
  logic [req_width_p-1:0] req_q,   req_d;
  logic                   owner_q, owner_d;
  logic [credits_p-1:0]   own_q,   own_d;

  logic idle, dmd_ok, pf_ok, pf_force;
  logic dmd_grant, pf_grant, send, drop, pop, head_owner;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Eligibility, grant arbitration and event decode for the current cycle
  always_comb begin
    idle            = (state_q == e_idle) & ~reset_i;
    dmd_ok          = count_q < credits_lp;
    // The last credit is kept back so a demand miss can always issue.
    pf_ok           = (count_q < pf_cap_lp) & ~flush_i;
    pf_force        = pf_v_i & pf_ok & (starve_q == starve_lim_lp);
    dmd_ready_and_o = idle & dmd_ok & ~pf_force;
    pf_ready_and_o  = idle & pf_ok & (~dmd_v_i | ~dmd_ok | pf_force);
    dmd_grant       = dmd_v_i & dmd_ready_and_o;
    pf_grant        = pf_v_i & pf_ready_and_o;
    send            = (state_q == e_send) & cache_req_ready_and_i & ~reset_i;
    // A held prefetch is discarded on flush unless the engine takes it this cycle.
    drop            = (state_q == e_send) & owner_q & flush_i & ~cache_req_ready_and_i;
    // Completions with nothing outstanding are ignored so the count never wraps.
    pop             = cache_req_complete_i & (count_q != '0) & ~reset_i;
    head_owner      = own_q[rd_ptr_q];
  end

  assign cache_req_v_o   = (state_q == e_send) & ~reset_i;
  assign cache_req_o     = req_q;
  assign dmd_complete_o  = pop & ~head_owner;
  assign pf_complete_o   = pop &  head_owner;
  assign credits_full_o  = ~reset_i & (count_q == credits_lp);
  assign credits_empty_o = reset_i | ((count_q == '0) & (state_q == e_idle));

  // Next-state: skid stage fill/drain, owner FIFO push/pop, credit and starve tracking
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    starve_d = starve_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    req_d    = req_q;
    owner_d  = owner_q;
    own_d    = own_q;

    if (dmd_grant) begin
      req_d   = dmd_req_i;
      owner_d = 1'b0;
      state_d = e_send;
    end else if (pf_grant) begin
      req_d   = pf_req_i;
      owner_d = 1'b1;
      state_d = e_send;
    end

    if (send) begin
      own_d[wr_ptr_q] = owner_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      state_d         = e_idle;
    end else if (drop) begin
      state_d = e_idle;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({send, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase

    // Count demand wins that pass over a waiting, eligible prefetch.
    if (!pf_v_i || pf_grant) begin
      starve_d = '0;
    end else if (dmd_grant && pf_ok && (starve_q != starve_lim_lp)) begin
      starve_d = starve_q + stv_w_lp'(1);
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      count_q  <= '0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data registers; their contents are only meaningful under the control state
  always_ff @(posedge clk_i) begin
    req_q   <= req_d;
    owner_q <= owner_d;
    own_q   <= own_d;
  end

  // A completion with no outstanding request is a requester protocol violation.
  if (check_proto_p) begin : g_proto_chk
    assert property (@(posedge clk_i) disable iff (reset_i)
                     cache_req_complete_i |-> (count_q != '0));
  end

endmodule

// File: tb/tb_bp_fe_fill_arbiter.sv
// Directed bench for bp_fe_fill_arbiter with a queue-based reference model.
module tb_bp_fe_fill_arbiter;
  localparam int W    = 16;
  localparam int CRED = 4;
  localparam int LIM  = 3;

  logic         clk = 1'b0;
  logic         rst, flush, dv, pv, rdy, cmp;
  logic [W-1:0] dpkt, ppkt;
  logic         dmd_ready_and_o, dmd_complete_o, pf_ready_and_o, pf_complete_o;
  logic [W-1:0] cache_req_o;
  logic         cache_req_v_o, credits_full_o, credits_empty_o;

  always #5 clk = ~clk;

  bp_fe_fill_arbiter #(
    .req_width_p   (W),
    .credits_p     (CRED),
    .starve_limit_p(LIM),
    .check_proto_p (1'b0)
  ) dut (
    .clk_i                (clk),
    .reset_i              (rst),
    .flush_i              (flush),
    .dmd_req_i            (dpkt),
    .dmd_v_i              (dv),
    .dmd_ready_and_o      (dmd_ready_and_o),
    .dmd_complete_o       (dmd_complete_o),
    .pf_req_i             (ppkt),
    .pf_v_i               (pv),
    .pf_ready_and_o       (pf_ready_and_o),
    .pf_complete_o        (pf_complete_o),
    .cache_req_o          (cache_req_o),
    .cache_req_v_o        (cache_req_v_o),
    .cache_req_ready_and_i(rdy),
    .cache_req_complete_i (cmp),
    .credits_full_o       (credits_full_o),
    .credits_empty_o      (credits_empty_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: skid slot plus a queue of owners (0=demand, 1=prefetch)
  bit           m_held;
  bit           m_own;
  logic [W-1:0] m_pkt;
  int           m_starve;
  bit           m_q[$];
  byte          glog[$];

  // Per-cycle compare against the model, then advance the model by one clock
  always @(negedge clk) begin
    bit e_v, e_dr, e_pr, e_dc, e_pc, e_full, e_empty, dok, pok, frc, pop, gd, gp;
    int occ;
    occ = m_q.size();
    if (rst) begin
      e_v = 0; e_dr = 0; e_pr = 0; e_dc = 0; e_pc = 0; e_full = 0; e_empty = 1;
      gd = 0; gp = 0; pop = 0;
    end else begin
      dok     = occ < CRED;
      pok     = (occ < CRED - 1) && !flush;
      frc     = pv && pok && (m_starve == LIM);
      e_dr    = !m_held && dok && !frc;
      e_pr    = !m_held && pok && (!dv || !dok || frc);
      pop     = cmp && (occ > 0);
      e_dc    = pop && !m_q[0];
      e_pc    = pop && m_q[0];
      e_v     = m_held;
      e_full  = (occ == CRED);
      e_empty = (occ == 0) && !m_held;
      gd      = dv && e_dr;
      gp      = pv && e_pr;
    end

    chk("cache_req_v", cache_req_v_o, e_v);
    chk("dmd_ready", dmd_ready_and_o, e_dr);
    chk("pf_ready", pf_ready_and_o, e_pr);
    chk("dmd_complete", dmd_complete_o, e_dc);
    chk("pf_complete", pf_complete_o, e_pc);
    chk("credits_full", credits_full_o, e_full);
    chk("credits_empty", credits_empty_o, e_empty);
    if (e_v) chk("cache_req", cache_req_o, m_pkt);

    if (dv && dmd_ready_and_o) glog.push_back("D");
    else if (pv && pf_ready_and_o) glog.push_back("P");

    if (rst) begin
      m_held = 0;
      m_q.delete();
      m_starve = 0;
    end else begin
      if (!pv || gp) m_starve = 0;
      else if (gd && pok) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      if (pop) void'(m_q.pop_front());
      if (m_held && rdy) begin
        m_q.push_back(m_own);
        m_held = 0;
      end else if (m_held && flush && m_own) begin
        m_held = 0;
      end
      if (gd) begin
        m_held = 1; m_own = 0; m_pkt = dpkt;
      end else if (gp) begin
        m_held = 1; m_own = 1; m_pkt = ppkt;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string exp_s;
    rst = 1; flush = 0; dv = 1; pv = 1; rdy = 0; cmp = 0;
    dpkt = '0; ppkt = '0;
    nxt();
    @(negedge clk);
    chk("rst_v", cache_req_v_o, 0);
    chk("rst_empty", credits_empty_o, 1);
    chk("rst_dready", dmd_ready_and_o, 0);
    chk("rst_pready", pf_ready_and_o, 0);
    nxt(); rst = 0; dv = 0; pv = 0;

    // Single demand, completion five cycles after acceptance
    nxt(); dv = 1; dpkt = 16'hA001; rdy = 1;
    @(negedge clk); chk("t1_dready", dmd_ready_and_o, 1);
    nxt(); dv = 0;
    @(negedge clk); chk("t1_v", cache_req_v_o, 1); chk("t1_pkt", cache_req_o, 16'hA001);
    nxt();
    chk("t1_mcnt", m_q.size(), 1);
    @(negedge clk); chk("t1_busy", credits_empty_o, 0);
    nxt(); nxt(); nxt(); cmp = 1;
    @(negedge clk); chk("t1_dcmp", dmd_complete_o, 1);
    nxt(); cmp = 0;
    @(negedge clk); chk("t1_empty", credits_empty_o, 1);

    // Credit reserve: three prefetches, then the held-back credit goes to a demand
    nxt(); pv = 1; ppkt = 16'hB000; rdy = 1;
    repeat (6) begin nxt(); ppkt = ppkt + 1'b1; end
    chk("t2_mcnt", m_q.size(), 3);
    dv = 1; dpkt = 16'hA002;
    @(negedge clk); chk("t2_pready", pf_ready_and_o, 0); chk("t2_dready", dmd_ready_and_o, 1);
    nxt(); nxt();
    @(negedge clk); chk("t2_full", credits_full_o, 1); chk("t2_dblock", dmd_ready_and_o, 0);
    nxt(); dv = 0; pv = 0; cmp = 1;
    @(negedge clk); chk("t2_pcmp", pf_complete_o, 1);
    repeat (3) nxt();
    @(negedge clk); chk("t2_dcmp_last", dmd_complete_o, 1);
    nxt(); cmp = 0;
    @(negedge clk); chk("t2_empty", credits_empty_o, 1);

    // Starvation bound with both requesters continuously valid
    nxt(); glog.delete(); dv = 1; pv = 1; rdy = 1;
    for (int i = 0; i < 16; i++) begin
      cmp = (i > 0) && (i % 2 == 0);
      dpkt = 16'hA100 + 16'(i);
      ppkt = 16'hB100 + 16'(i);
      nxt();
    end
    dv = 0; pv = 0; cmp = 1;
    nxt(); cmp = 0;
    exp_s = "DDDPDDDP";
    chk("t3_ngrants", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_grant%0d", i), (i < glog.size()) ? glog[i] : 8'h0, exp_s[i]);
    @(negedge clk); chk("t3_empty", credits_empty_o, 1);

    // Flush drops a held prefetch when the engine is not ready
    nxt(); pv = 1; ppkt = 16'hB200; rdy = 0;
    nxt(); pv = 0; flush = 1;
    @(negedge clk); chk("t4_held", cache_req_v_o, 1);
    nxt(); flush = 0;
    @(negedge clk); chk("t4_dropped", cache_req_v_o, 0); chk("t4_idle_empty", credits_empty_o, 1);
    repeat (3) nxt();
    // Engine handshake in the flush cycle wins
    pv = 1; ppkt = 16'hB201;
    nxt(); pv = 0; flush = 1; rdy = 1;
    nxt(); flush = 0; rdy = 0;
    chk("t4_sent_cnt", m_q.size(), 1);
    @(negedge clk); chk("t4_sent_v", cache_req_v_o, 0); chk("t4_sent_busy", credits_empty_o, 0);
    nxt(); cmp = 1;
    @(negedge clk); chk("t4_pcmp", pf_complete_o, 1);
    nxt(); cmp = 0;
    // A held demand survives flush
    dv = 1; dpkt = 16'hA200;
    nxt(); dv = 0; flush = 1;
    nxt(); flush = 0; rdy = 1;
    @(negedge clk); chk("t4_dkeep_v", cache_req_v_o, 1); chk("t4_dkeep_pkt", cache_req_o, 16'hA200);
    nxt(); rdy = 0; cmp = 1;
    @(negedge clk); chk("t4_dcmp", dmd_complete_o, 1);
    nxt(); cmp = 0;

    // Completion ordering D,P,D with a send and a complete in the same cycle
    rdy = 1; dv = 1; dpkt = 16'hA300;
    nxt(); dv = 0;
    nxt(); pv = 1; ppkt = 16'hB300;
    nxt(); pv = 0;
    nxt(); dv = 1; dpkt = 16'hA301;
    nxt(); dv = 0; cmp = 1;
    @(negedge clk); chk("t5_c1_d", dmd_complete_o, 1); chk("t5_c1_p", pf_complete_o, 0);
    nxt();
    chk("t5_same_cnt", m_q.size(), 2);
    @(negedge clk); chk("t5_c2_p", pf_complete_o, 1);
    nxt();
    @(negedge clk); chk("t5_c3_d", dmd_complete_o, 1);
    nxt(); cmp = 0;
    @(negedge clk); chk("t5_empty", credits_empty_o, 1);

    // Reset with two outstanding and a packet held, then a stray completion
    nxt(); rdy = 1; dv = 1; dpkt = 16'hA400;
    nxt(); dv = 0;
    nxt(); dv = 1; dpkt = 16'hA401;
    nxt(); dv = 0;
    nxt(); dv = 1; dpkt = 16'hA402; rdy = 0;
    nxt(); dv = 0;
    chk("t6_pre_cnt", m_q.size(), 2);
    @(negedge clk); chk("t6_pre_v", cache_req_v_o, 1);
    nxt(); rst = 1;
    nxt(); rst = 0;
    chk("t6_cnt", m_q.size(), 0);
    @(negedge clk);
    chk("t6_v", cache_req_v_o, 0);
    chk("t6_empty", credits_empty_o, 1);
    chk("t6_full", credits_full_o, 0);
    nxt(); cmp = 1;
    @(negedge clk); chk("t6_stray_d", dmd_complete_o, 0); chk("t6_stray_p", pf_complete_o, 0);
    nxt(); cmp = 0;
    @(negedge clk); chk("t6_empty_after", credits_empty_o, 1);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
